// File: rtl/frame_sequencer.sv
// frame_sequencer: Moore FSM that steps the game datapath through one frame
// (idle wait, move generation, collision check, link/enemy update, three draw
// passes) and counts completed frames.
// Optional watchdog: define FRAME_SEQ_TIMEOUT_EN to bound the dwell in every
// done-wait state to TIMEOUT_CYCLES and raise a sticky timeout_err.
module frame_sequencer #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pause,
    input  logic        idle_done,
    input  logic        check_collide_done,
    input  logic        draw_map_done,
    input  logic        draw_link_done,
    input  logic        draw_enemies_done,
    output logic        init,
    output logic        idle,
    output logic        gen_move,
    output logic        check_collide,
    output logic        apply_act_link,
    output logic        move_enemies,
    output logic        draw_map,
    output logic        draw_link,
    output logic        draw_enemies,
    output logic [15:0] frame_count,
    output logic [3:0]  state,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        S_INIT          = 4'd0,
        S_IDLE          = 4'd1,
        S_GEN_MOVE      = 4'd2,
        S_CHECK_COLLIDE = 4'd3,
        S_APPLY_LINK    = 4'd4,
        S_MOVE_ENEMIES  = 4'd5,
        S_DRAW_MAP      = 4'd6,
        S_DRAW_LINK     = 4'd7,
        S_DRAW_ENEMIES  = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   frame_count_q, frame_count_d;
    // Cycles spent in the current wait state; zero means first cycle, which
    // is what lets a done left high from the previous step be ignored.
    logic [19:0]   dwell_q, dwell_d;
    logic          is_wait;
    logic          done_sel;
    logic          expired;
    logic          advance;

    // Select the done input that belongs to the current wait state
    always_comb begin
        is_wait  = 1'b0;
        done_sel = 1'b0;
        case (state_q)
            S_CHECK_COLLIDE: begin is_wait = 1'b1; done_sel = check_collide_done; end
            S_DRAW_MAP:      begin is_wait = 1'b1; done_sel = draw_map_done;      end
            S_DRAW_LINK:     begin is_wait = 1'b1; done_sel = draw_link_done;     end
            S_DRAW_ENEMIES:  begin is_wait = 1'b1; done_sel = draw_enemies_done;  end
            default:         begin is_wait = 1'b0; done_sel = 1'b0;               end
        endcase
    end

`ifdef FRAME_SEQ_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;
    assign expired     = is_wait && (dwell_q == TIMEOUT_CYCLES - 20'd1);
    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expired        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    assign advance = is_wait && ((done_sel && (dwell_q != 20'd0)) || expired);

    // Next-state, frame counter and dwell counter logic
    always_comb begin
        state_d       = state_q;
        frame_count_d = frame_count_q;
        dwell_d       = dwell_q;
`ifdef FRAME_SEQ_TIMEOUT_EN
        timeout_err_d = timeout_err_q | expired;
`endif
        case (state_q)
            S_INIT:          state_d = S_IDLE;
            S_IDLE:          if (idle_done && !pause) state_d = S_GEN_MOVE;
            S_GEN_MOVE:      state_d = S_CHECK_COLLIDE;
            S_CHECK_COLLIDE: if (advance) state_d = S_APPLY_LINK;
            S_APPLY_LINK:    state_d = S_MOVE_ENEMIES;
            S_MOVE_ENEMIES:  state_d = S_DRAW_MAP;
            S_DRAW_MAP:      if (advance) state_d = S_DRAW_LINK;
            S_DRAW_LINK:     if (advance) state_d = S_DRAW_ENEMIES;
            S_DRAW_ENEMIES:  if (advance) begin
                state_d       = S_IDLE;
                frame_count_d = frame_count_q + 16'd1;
            end
            default:         state_d = S_INIT;
        endcase

        if (state_d != state_q) begin
            dwell_d = 20'd0;
        end else if (is_wait) begin
`ifdef FRAME_SEQ_TIMEOUT_EN
            dwell_d = dwell_q + 20'd1;
`else
            // Only "first cycle or not" matters here, so saturate at one
            dwell_d = (dwell_q == 20'd0) ? 20'd1 : dwell_q;
`endif
        end
    end

    // State, counter and watchdog registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_INIT;
            frame_count_q <= 16'd0;
            dwell_q       <= 20'd0;
`ifdef FRAME_SEQ_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            frame_count_q <= frame_count_d;
            dwell_q       <= dwell_d;
`ifdef FRAME_SEQ_TIMEOUT_EN
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // Control strobes decoded from the state register alone
    assign init           = (state_q == S_INIT);
    assign idle           = (state_q == S_IDLE);
    assign gen_move       = (state_q == S_GEN_MOVE);
    assign check_collide  = (state_q == S_CHECK_COLLIDE);
    assign apply_act_link = (state_q == S_APPLY_LINK);
    assign move_enemies   = (state_q == S_MOVE_ENEMIES);
    assign draw_map       = (state_q == S_DRAW_MAP);
    assign draw_link      = (state_q == S_DRAW_LINK);
    assign draw_enemies   = (state_q == S_DRAW_ENEMIES);
    assign frame_count    = frame_count_q;
    assign state          = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed checks of reset, full frame, pause, foreign
// dones, watchdog and mid-frame reset, then random frames scored against a
// frame schedule pushed into an expected-transition queue.
module tb_frame_sequencer;

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam logic [19:0] TO = 20'd8;
`else
    localparam logic [19:0] TO = 20'd1000000;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pause = 1'b0;
    logic        idle_done = 1'b0;
    logic [3:0]  dn = 4'd0;   // {enemies, link, map, collide} dones
    logic        init, idle, gen_move, check_collide, apply_act_link;
    logic        move_enemies, draw_map, draw_link, draw_enemies;
    logic [15:0] frame_count;
    logic [3:0]  state;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    typedef struct { int st; int fc; } exp_t;
    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   prev_st = 0;

    frame_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .pause(pause), .idle_done(idle_done),
        .check_collide_done(dn[0]), .draw_map_done(dn[1]),
        .draw_link_done(dn[2]), .draw_enemies_done(dn[3]),
        .init(init), .idle(idle), .gen_move(gen_move),
        .check_collide(check_collide), .apply_act_link(apply_act_link),
        .move_enemies(move_enemies), .draw_map(draw_map),
        .draw_link(draw_link), .draw_enemies(draw_enemies),
        .frame_count(frame_count), .state(state), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: strobe decode every cycle, scoreboard pop on each state change
    always @(negedge clock) begin
        if (mon_en) begin
            logic [8:0] ctrl;
            exp_t e;
            ctrl = {draw_enemies, draw_link, draw_map, move_enemies,
                    apply_act_link, check_collide, gen_move, idle, init};
            if (state < 4'd9) check("onehot", int'(ctrl), 1 << state);
            else              check("onehot_illegal", int'(ctrl), 0);
            if (int'(state) != prev_st) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transition", int'(state), prev_st);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_state", int'(state), e.st);
                    check("sb_frame_count", int'(frame_count), e.fc);
                    check("sb_timeout_err", int'(timeout_err), 0);
                end
                prev_st = int'(state);
            end
        end
    end

    // One done-wait state: own done rises d cycles in, held; others random
    task automatic wait_seg(input int k);
        int d, len;
        d   = $urandom_range(0, 4);
        len = (d + 1 < 2) ? 2 : d + 1;
        for (int i = 0; i < len; i++) begin
            dn        = 4'($urandom);
            dn[k]     = (i >= d);
            pause     = 1'($urandom);
            idle_done = 1'($urandom);
            step();
        end
    endtask

    task automatic run_frame(input int fc_now);
        int n;
        int seq[7] = '{2, 3, 4, 5, 6, 7, 8};
        foreach (seq[i]) exp_q.push_back('{st: seq[i], fc: fc_now});
        exp_q.push_back('{st: 1, fc: (fc_now + 1) & 16'hFFFF});
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            idle_done = 1'b0;
            pause     = 1'($urandom);
            dn        = 4'($urandom);
            step();
        end
        idle_done = 1'b1; pause = 1'b0; dn = 4'($urandom);
        step();                                   // -> gen_move
        idle_done = 1'($urandom); pause = 1'($urandom); dn = 4'($urandom);
        step();                                   // -> check_collide
        wait_seg(0);                              // -> apply_link
        dn = 4'($urandom); pause = 1'($urandom);
        step();                                   // -> move_enemies
        dn = 4'($urandom);
        step();                                   // -> draw_map
        wait_seg(1);
        wait_seg(2);
        wait_seg(3);                              // -> idle
    endtask

    initial begin
        int seq[12] = '{2, 3, 3, 4, 5, 6, 6, 7, 7, 8, 8, 1};
        int cnt;
        int frames;

        // Reset state, then one init cycle, then idle
        repeat (2) @(negedge clock);
        check("rst_state", int'(state), 0);
        check("rst_init", int'(init), 1);
        check("rst_idle", int'(idle), 0);
        check("rst_fc", int'(frame_count), 0);
        check("rst_timeout", int'(timeout_err), 0);
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        check("init_cycle", int'(init), 1);
        step();
        check("idle_after_init", int'(idle), 1);
        check("idle_state", int'(state), 1);
        check("idle_fc", int'(frame_count), 0);

        // Full frame at minimum dwell with every done held high
        dn = 4'hF; idle_done = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            idle_done = 1'b0;
            check($sformatf("minframe_%0d", i), int'(state), seq[i]);
        end
        check("minframe_fc", int'(frame_count), 1);
        dn = 4'h0;

        // Pause holds idle regardless of idle_done pulses
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle_done = 1'b1; step(); check("pause_hold", int'(state), 1);
            idle_done = 1'b0; step(); check("pause_hold", int'(state), 1);
        end
        check("pause_fc", int'(frame_count), 1);
        pause = 1'b0; idle_done = 1'b1;
        step();
        idle_done = 1'b0;
        check("unpause_gen_move", int'(gen_move), 1);

        // Foreign done (draw_link_done) must not move draw_map
        dn = 4'b0101;
        step(); step(); step(); step(); step();
        check("enter_draw_map", int'(state), 6);
        dn = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step(); check("map_ignores_link_done", int'(state), 6);
        end
        dn = 4'b0110; step(); check("map_exit", int'(state), 7);
        dn = 4'b0100; step(); check("link_guard", int'(state), 7);
        step(); check("link_exit", int'(state), 8);
        dn = 4'b1000; step(); check("enemies_guard", int'(state), 8);
        step(); check("enemies_exit", int'(state), 1);
        check("frame2_fc", int'(frame_count), 2);
        dn = 4'b0000;

        // Draw_map with its done never asserted
        idle_done = 1'b1; dn = 4'b0001;
        step(); idle_done = 1'b0;
        repeat (5) step();
        check("to_enter_map", int'(state), 6);
        dn = 4'b0000;
        cnt = 1;
`ifdef FRAME_SEQ_TIMEOUT_EN
        for (int i = 0; i < 30; i++) begin
            step();
            if (state != 4'd6) break;
            cnt++;
        end
        check("to_dwell", cnt, 8);
        check("to_next_state", int'(state), 7);
        check("to_err_set", int'(timeout_err), 1);
`else
        for (int i = 0; i < 15; i++) begin
            step();
            if (state == 4'd6) cnt++;
        end
        check("no_to_wait", cnt, 16);
        check("no_to_err", int'(timeout_err), 0);
        dn = 4'b0010; step();
        check("no_to_exit", int'(state), 7);
`endif
        dn = 4'b1100;
        step(); step(); step(); step();
        check("frame3_idle", int'(state), 1);
        check("frame3_fc", int'(frame_count), 3);
`ifdef FRAME_SEQ_TIMEOUT_EN
        check("to_err_sticky", int'(timeout_err), 1);
`else
        check("err_tied", int'(timeout_err), 0);
`endif

        // Reset while in draw_link with three frames counted
        idle_done = 1'b1; dn = 4'b0011;
        step(); idle_done = 1'b0;
        repeat (7) step();
        check("pre_rst_state", int'(state), 7);
        check("pre_rst_draw_link", int'(draw_link), 1);
        check("pre_rst_fc", int'(frame_count), 3);
        reset = 1'b1;
        #1;
        check("midrst_state", int'(state), 0);
        check("midrst_fc", int'(frame_count), 0);
        check("midrst_draw_link", int'(draw_link), 0);
        check("midrst_init", int'(init), 1);
        check("midrst_timeout", int'(timeout_err), 0);
        @(posedge clock); #1; reset = 1'b0; dn = 4'b0000;
        step();
        check("post_rst_idle", int'(state), 1);

        // Random frames, scored by the monitor
        prev_st = 1;
        mon_en  = 1'b1;
        frames  = 40;
        for (int f = 0; f < frames; f++) run_frame(f);
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clock);
        @(negedge clock);
        mon_en = 1'b0;
        check("sb_drained", exp_q.size(), 0);
        check("rand_fc", int'(frame_count), frames);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

endmodule
